// File: rtl/stream_conv2d_pkg.sv
// Shared sizing helpers, stage tag and saturation for stream_conv2d.
// Imported by the interface, the line buffer user and the top level.
package conv_pkg;

    // Valid/start-of-frame tag travelling alongside each pipeline stage.
    typedef struct packed {
        logic valid;
        logic sof;
    } pipe_tag_t;

    // Address width for an n-entry structure, never below one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator width: full products plus growth for k*k terms.
    function automatic int acc_w(input int k, input int w);
        return 2 * w + $clog2(k * k);
    endfunction

    // Flat coefficient index for window position [r][c].
    function automatic int coef_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

    // Floor shift, then clip into a signed wsz-bit range.
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] acc,
        input int                 shift,
        input int                 wsz
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = acc >>> shift;
        hi = (64'sd1 <<< (wsz - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (wsz - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/stream_conv2d_if.sv
// Pixel stream, coefficient port and result stream of one conv channel.
// master drives pixels/coefficients, slave is the convolution engine.
interface stream_conv2d_if
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int WORD_SIZE   = 8
);
    localparam int CA_W = addr_w(KERNEL_SIZE * KERNEL_SIZE);

    logic                        in_valid;
    logic                        in_sof;
    logic signed [WORD_SIZE-1:0] in_pixel;
    logic                        coef_we;
    logic [CA_W-1:0]             coef_addr;
    logic signed [WORD_SIZE-1:0] coef_data;
    logic                        relu_en;
    logic                        out_valid;
    logic                        out_sof;
    logic signed [WORD_SIZE-1:0] out_pixel;
    logic                        overrun;

    modport master (
        output in_valid, in_sof, in_pixel,
        output coef_we, coef_addr, coef_data, relu_en,
        input  out_valid, out_sof, out_pixel, overrun
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        input  coef_we, coef_addr, coef_data, relu_en,
        output out_valid, out_sof, out_pixel, overrun
    );

endinterface

// File: rtl/stream_conv2d_line_buffer.sv
// One image line of storage, 1R1W with a registered read port.
// Contents are not reset; only positions already written are consumed.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write the shifted column entry and register the look-ahead read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/stream_conv2d.sv
// Streaming KxK correlation: line buffers, window, MAC pipeline, clip.
// Latency from pixel acceptance to visible result is four cycles.
module stream_conv2d
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int WORD_SIZE   = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int SHIFT       = 0
) (
    input logic          clk,
    input logic          reset_n,
    stream_conv2d_if.slave bus
);
    localparam int K     = KERNEL_SIZE;
    localparam int W     = WORD_SIZE;
    localparam int KK    = K * K;
    localparam int PW    = 2 * W;
    localparam int ACC_W = acc_w(K, W);
    localparam int COL_W = addr_w(IMG_WIDTH);
    localparam int ROW_W = addr_w(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_EDGE = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(K - 1);

    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic                    r_done;
    logic                    r_framed;
    logic                    r_overrun;

    logic                    w_accept;
    logic [COL_W-1:0]        w_pos_col;
    logic [ROW_W-1:0]        w_pos_row;
    logic                    w_col_wrap;
    logic                    w_last;
    logic [COL_W-1:0]        w_col_inc;
    logic [ROW_W-1:0]        w_row_inc;
    logic [COL_W-1:0]        w_col_next;
    logic                    w_in_region;
    logic                    w_first;

    logic signed [W-1:0]     w_lb_rd [K-1];
    logic signed [W-1:0]     w_lb_wd [K-1];
    logic signed [W-1:0]     r_win   [K][K];
    logic signed [W-1:0]     r_coef  [KK];
    logic signed [PW-1:0]    r_prod  [KK];
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [63:0]      w_sat;
    logic signed [W-1:0]     w_clip;

    pipe_tag_t               r_tag0;
    pipe_tag_t               r_tag1;
    pipe_tag_t               r_tag2;

    logic                    r_out_valid;
    logic                    r_out_sof;
    logic signed [W-1:0]     r_out_pixel;

    // Position of the incoming pixel and the counter values that follow it.
    always_comb begin
        w_accept    = bus.in_valid && (bus.in_sof || !r_done);
        w_pos_col   = bus.in_sof ? '0 : r_col;
        w_pos_row   = bus.in_sof ? '0 : r_row;
        w_col_wrap  = (w_pos_col == COL_LAST);
        w_last      = w_col_wrap && (w_pos_row == ROW_LAST);
        w_col_inc   = w_col_wrap ? '0 : w_pos_col + COL_W'(1);
        w_row_inc   = w_pos_row;
        if (w_col_wrap) begin
            w_row_inc = w_last ? '0 : w_pos_row + ROW_W'(1);
        end
        w_col_next  = w_accept ? w_col_inc : r_col;
        w_first     = (w_pos_row == ROW_EDGE) && (w_pos_col == COL_EDGE);
        w_in_region = w_accept && (r_framed || bus.in_sof)
                      && (w_pos_row >= ROW_EDGE)
                      && (w_pos_col >= COL_EDGE);
    end

    // Raster counters, frame-complete flag and sticky overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_done    <= 1'b0;
            r_framed  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_col  <= w_col_inc;
                r_row  <= w_row_inc;
                r_done <= w_last;
            end
            if (bus.in_valid && bus.in_sof) begin
                r_framed  <= 1'b1;
                r_overrun <= 1'b0;
            end else if (bus.in_valid && r_done) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Column entries move up one line buffer per accepted pixel.
    always_comb begin
        w_lb_wd[0] = bus.in_pixel;
        for (int j = 1; j < K - 1; j++) begin
            w_lb_wd[j] = w_lb_rd[j-1];
        end
    end

    // Reads look one pixel ahead so the column is ready on acceptance.
    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        line_buffer #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (W),
            .AW    (COL_W)
        ) u_lb (
            .clk     (clk),
            .i_we    (w_accept),
            .i_waddr (w_pos_col),
            .i_wdata (w_lb_wd[j]),
            .i_raddr (w_col_next),
            .o_rdata (w_lb_rd[j])
        );
    end

    // Window shifts left; newest column enters at the right edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
            end
            for (int j = 0; j < K - 1; j++) begin
                r_win[K-2-j][K-1] <= w_lb_rd[j];
            end
            r_win[K-1][K-1] <= bus.in_pixel;
        end
    end

    // Coefficient register file; out-of-range addresses are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < KK; i++) begin
                r_coef[i] <= '0;
            end
        end else if (bus.coef_we && (int'(bus.coef_addr) < KK)) begin
            r_coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Full-width signed products of window and coefficients.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < KK; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_prod[coef_idx(r, c, K)] <=
                        PW'(r_win[r][c]) * PW'(r_coef[coef_idx(r, c, K)]);
                end
            end
        end
    end

    // Sign-extended sum of all products.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < KK; i++) begin
            w_sum = w_sum + ACC_W'(r_prod[i]);
        end
    end

    // Register the accumulated sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum;
        end
    end

    // Shift, saturate, then optional ReLU clamp.
    always_comb begin
        w_sat  = saturate(64'(r_acc), SHIFT, W);
        w_clip = (bus.relu_en && (w_sat < 64'sd0)) ? '0 : w_sat[W-1:0];
    end

    // Valid and frame-start tags travel with the data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag0 <= '0;
            r_tag1 <= '0;
            r_tag2 <= '0;
        end else begin
            r_tag0.valid <= w_in_region;
            r_tag0.sof   <= w_in_region && w_first;
            r_tag1       <= r_tag0;
            r_tag2       <= r_tag1;
        end
    end

    // Registered output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_pixel <= '0;
        end else begin
            r_out_valid <= r_tag2.valid;
            r_out_sof   <= r_tag2.sof;
            if (r_tag2.valid) begin
                r_out_pixel <= w_clip;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sof   = r_out_sof;
    assign bus.out_pixel = r_out_pixel;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_stream_conv2d.sv
// Randomized bench for stream_conv2d against an image-level reference.
// Two instances (SHIFT 0 and 3) share one stimulus stream.
module tb_stream_conv2d;
    localparam int K    = 3;
    localparam int W    = 8;
    localparam int IW   = 8;
    localparam int IH   = 6;
    localparam int KK   = K * K;
    localparam int CA_W = 4;
    localparam int NOUT = (IW - K + 1) * (IH - K + 1);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    stream_conv2d_if #(.KERNEL_SIZE(K), .WORD_SIZE(W)) bus0 ();
    stream_conv2d_if #(.KERNEL_SIZE(K), .WORD_SIZE(W)) bus3 ();

    assign bus3.in_valid  = bus0.in_valid;
    assign bus3.in_sof    = bus0.in_sof;
    assign bus3.in_pixel  = bus0.in_pixel;
    assign bus3.coef_we   = bus0.coef_we;
    assign bus3.coef_addr = bus0.coef_addr;
    assign bus3.coef_data = bus0.coef_data;
    assign bus3.relu_en   = bus0.relu_en;

    stream_conv2d #(
        .KERNEL_SIZE (K), .WORD_SIZE (W), .IMG_WIDTH (IW),
        .IMG_HEIGHT  (IH), .SHIFT (0)
    ) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    stream_conv2d #(
        .KERNEL_SIZE (K), .WORD_SIZE (W), .IMG_WIDTH (IW),
        .IMG_HEIGHT  (IH), .SHIFT (3)
    ) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    typedef struct {
        longint cyc;
        bit     sof;
        longint val;
    } exp_t;

    exp_t   q0[$];
    exp_t   q3[$];
    int     n_cmp  = 0;
    int     n_bad  = 0;
    int     n_out0 = 0;
    int     n_out3 = 0;
    longint cyc    = 0;

    longint m_img  [IH][IW];
    longint m_coef [K][K];
    int     m_row, m_col;
    bit     m_done, m_framed, m_overrun, m_relu;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Floor division by 2^sh, clip to signed W bits, optional ReLU.
    function automatic longint clip(input longint s, input int sh, input bit relu);
        longint d, q;
        d = 1;
        for (int i = 0; i < sh; i++) d = d * 2;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        if (relu && q < 0) q = 0;
        return q;
    endfunction

    task automatic model_reset();
        m_row = 0; m_col = 0; m_done = 0; m_framed = 0; m_overrun = 0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) m_coef[r][c] = 0;
    endtask

    // Place the pixel in the frame image and predict any result.
    task automatic model_pixel(input bit sof, input longint pix);
        int     pr, pc;
        longint sum;
        if (sof) begin
            pr = 0; pc = 0; m_framed = 1; m_overrun = 0;
        end else if (m_done) begin
            m_overrun = 1;
            return;
        end else begin
            pr = m_row; pc = m_col;
        end
        m_img[pr][pc] = pix;
        if (m_framed && pr >= K - 1 && pc >= K - 1) begin
            sum = 0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    sum += m_coef[r][c] * m_img[pr-K+1+r][pc-K+1+c];
            q0.push_back('{cyc + 4, (pr == K-1 && pc == K-1), clip(sum, 0, m_relu)});
            q3.push_back('{cyc + 4, (pr == K-1 && pc == K-1), clip(sum, 3, m_relu)});
        end
        m_done = (pr == IH - 1) && (pc == IW - 1);
        m_col  = (pc + 1) % IW;
        m_row  = (pc == IW - 1) ? (pr + 1) % IH : pr;
    endtask

    task automatic send(input bit v, input bit sof, input longint pix);
        @(posedge clk); #1;
        bus0.in_valid = v;
        bus0.in_sof   = sof;
        bus0.in_pixel = W'(pix);
        if (v) model_pixel(sof, pix);
    endtask

    task automatic idle(input int n);
        repeat (n) send(0, 0, 0);
    endtask

    task automatic load_kernel(input int mode);
        int v;
        idle(6);
        for (int i = 0; i < KK; i++) begin
            case (mode)
                0:       v = (i == KK / 2) ? 1 : 0;
                1:       v = 1;
                2:       v = int'($urandom_range(0, 255)) - 128;
                default: v = int'($urandom_range(0, 8)) - 4;
            endcase
            @(posedge clk); #1;
            bus0.coef_we   = 1'b1;
            bus0.coef_addr = CA_W'(i);
            bus0.coef_data = W'(v);
            m_coef[i / K][i % K] = v;
        end
        @(posedge clk); #1;
        bus0.coef_we = 1'b0;
    endtask

    task automatic set_relu(input bit r);
        idle(6);
        bus0.relu_en = r;
        m_relu       = r;
    endtask

    function automatic longint pixval(input int mode, input int cval, input int r, input int c);
        case (mode)
            0:       return longint'(r * IW + c);
            1:       return longint'(cval);
            2:       return longint'(int'($urandom_range(0, 255)) - 128);
            default: return longint'(int'($urandom_range(0, 40)) - 20);
        endcase
    endfunction

    // gap: 0 back-to-back, 1 idle between pixels, 2 random idles.
    task automatic frame(input int mode, input int cval, input int gap);
        int c0, c3;
        c0 = n_out0;
        c3 = n_out3;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                if (gap == 1 && (r != 0 || c != 0)) send(0, 0, 0);
                if (gap == 2) repeat ($urandom_range(0, 2)) send(0, 0, 0);
                send(1, (r == 0 && c == 0), pixval(mode, cval, r, c));
            end
        end
        idle(6);
        check("count0", n_out0 - c0, NOUT);
        check("count3", n_out3 - c3, NOUT);
    endtask

    // Output monitor: every result must match the predicted value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (bus0.out_valid) begin
                n_out0++;
                if (q0.size() == 0) begin
                    check("spur0", bus0.out_valid, 0);
                end else begin
                    e = q0.pop_front();
                    check("val0", bus0.out_pixel, e.val);
                    check("sof0", bus0.out_sof, e.sof);
                    check("lat0", cyc, e.cyc);
                end
            end else if (q0.size() != 0 && q0[0].cyc <= cyc) begin
                check("miss0", bus0.out_valid, 1);
                q0.delete(0);
            end
            if (bus3.out_valid) begin
                n_out3++;
                if (q3.size() == 0) begin
                    check("spur3", bus3.out_valid, 0);
                end else begin
                    e = q3.pop_front();
                    check("val3", bus3.out_pixel, e.val);
                    check("sof3", bus3.out_sof, e.sof);
                    check("lat3", cyc, e.cyc);
                end
            end else if (q3.size() != 0 && q3[0].cyc <= cyc) begin
                check("miss3", bus3.out_valid, 1);
                q3.delete(0);
            end
        end
    end

    initial begin
        bus0.in_valid  = 1'b0;
        bus0.in_sof    = 1'b0;
        bus0.in_pixel  = '0;
        bus0.coef_we   = 1'b0;
        bus0.coef_addr = '0;
        bus0.coef_data = '0;
        bus0.relu_en   = 1'b0;
        m_relu         = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid0", bus0.out_valid, 0);
        check("rst_sof0",   bus0.out_sof,   0);
        check("rst_pix0",   bus0.out_pixel, 0);
        check("rst_ovr0",   bus0.overrun,   0);
        check("rst_valid3", bus3.out_valid, 0);
        check("rst_pix3",   bus3.out_pixel, 0);
        reset_n = 1'b1;

        load_kernel(0);
        frame(0, 0, 0);

        load_kernel(1);
        frame(1, 100, 0);
        frame(1, -100, 0);
        set_relu(1);
        frame(1, -100, 0);
        set_relu(0);
        frame(1, 10, 0);
        frame(1, -10, 0);

        load_kernel(0);
        frame(0, 0, 1);

        load_kernel(2);
        frame(2, 0, 2);
        load_kernel(3);
        frame(3, 0, 2);
        set_relu(1);
        frame(2, 0, 0);
        set_relu(0);

        // Full frame, one stray pixel, then reset while results are in flight.
        load_kernel(0);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                send(1, (r == 0 && c == 0), pixval(0, 0, r, c));
        send(1, 0, 55);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        check("pre_ovr",   bus0.overrun,   m_overrun);
        check("pre_valid", bus0.out_valid, 1);
        #1;
        reset_n = 1'b0;
        q0.delete();
        q3.delete();
        model_reset();
        #1;
        check("mid_valid0", bus0.out_valid, 0);
        check("mid_sof0",   bus0.out_sof,   0);
        check("mid_pix0",   bus0.out_pixel, 0);
        check("mid_ovr0",   bus0.overrun,   0);
        check("mid_valid3", bus3.out_valid, 0);
        check("mid_ovr3",   bus3.overrun,   0);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Without a frame start nothing may come out.
        load_kernel(0);
        for (int i = 0; i < 20; i++) send(1, 0, pixval(2, 0, 0, 0));
        idle(6);
        frame(0, 0, 0);

        // Stray pixel sets overrun; the next frame start clears it.
        send(1, 0, 77);
        idle(3);
        check("ovr_set", bus0.overrun, m_overrun);
        frame(0, 0, 0);
        check("ovr_clr", bus0.overrun, m_overrun);

        idle(6);
        check("left0", q0.size(), 0);
        check("left3", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_conv2d.md
# stream_conv2d

Streaming K×K 2-D convolution engine with full signed multipliers, wide accumulation, a fixed-point output shift and saturation clipping. Raster-order pixels enter one per valid cycle. Internal line buffers build the sliding window, so upstream no longer supplies a pre-assembled K×K buffer. The block sits between the pixel source and the per-channel post-processing; one instance serves one channel.

## Interface
- `KERNEL_SIZE`, 3: window edge K (odd, ≥3).
- `WORD_SIZE`, 8: signed width of pixels, coefficients and output.
- `IMG_WIDTH`, 640: pixels per line.
- `IMG_HEIGHT`, 480: lines per frame.
- `SHIFT`, 0: arithmetic right shift applied to the accumulated sum (fixed-point coefficients).
- `clk`  in  1: the only clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: a pixel is present this cycle.
- `in_sof`  in  1: qualifies the pixel as the first of a frame; ignored unless `in_valid`.
- `in_pixel`  in  WORD_SIZE: signed pixel.
- `coef_we`  in  1: coefficient write strobe.
- `coef_addr`  in  clog2(K*K): row*K+col.
- `coef_data`  in  WORD_SIZE: signed coefficient.
- `relu_en`  in  1: clamp negative results to 0 after saturation. Static within a frame.
- `out_valid`  out  1: `out_pixel` is valid.
- `out_sof`  out  1: first output of a frame.
- `out_pixel`  out  WORD_SIZE: clipped result.
- `overrun`  out  1: sticky; a pixel arrived beyond IMG_WIDTH×IMG_HEIGHT without `in_sof`.

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) advance on each accepted pixel. An accepted pixel with `in_sof` is position (0,0), whether at the start or in the middle of a frame.
- Line buffers: K-1 buffers, each IMG_WIDTH deep, addressed by `col`. On acceptance, column `col` shifts up through the buffers and the window shifts left by one column.
- Window rows are oldest line at index 0. Coefficient [r][c] multiplies window [r][c]. This is correlation order; no kernel flip.
- Output is produced only when `row ≥ K-1` and `col ≥ K-1` (valid region only, no padding). That gives (IMG_WIDTH-K+1)×(IMG_HEIGHT-K+1) outputs per frame. `out_sof` marks the output at (K-1,K-1).
- Arithmetic:
  - Each product is full 2·WORD_SIZE bits.
  - The accumulator is ACC_W = 2·WORD_SIZE + clog2(K*K) bits, so it cannot overflow.
  - The sum is shifted with `>>>SHIFT` (floor).
  - The result saturates to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1], then the ReLU clamp applies if `relu_en` is set.
- After the last pixel of a frame, further pixels without `in_sof` are dropped: counters hold, no output is produced, and `overrun` is set. An accepted `in_sof` clears `overrun`.
- Coefficients are written at any time and take effect for windows multiplied on the next cycle onward. Software loads them between frames.
- Window registers are stale after `in_sof`, but outputs stay suppressed until the region condition holds again.

## Timing
- Reset (`reset_n` low, asynchronous) drives these to 0: `out_valid`, `out_sof`, `out_pixel`, `overrun`, counters, coefficients and all pipeline valid bits. Line-buffer RAM contents are don't-care.
- Pipeline: pixel accepted at the edge ending cycle n:
  - edge n: window update;
  - edge n+1: products;
  - edge n+2: adder tree;
  - edge n+3: shift/clip.
  - `out_valid`, `out_sof` and `out_pixel` are therefore visible in cycle n+4. Latency is 4, fixed.
- No backpressure; throughput is one pixel per cycle. `in_valid` gaps produce matching `out_valid` gaps. Valid bits travel with data.
- A reset released mid-frame requires `in_sof` before any output.

## Structure
- `conv_pkg` holds: ACC_W and address-width functions, the `saturate(acc, SHIFT)` function, and the `coef_idx(r,c)` helper.
- Sub-module `line_buffer`: a 1R1W buffer, IMG_WIDTH deep and WORD_SIZE wide, with a registered read. Instantiate K-1 of them in a generate loop.
- Top level contains: counters, window registers, coefficient register file, MAC pipeline and output stage.

## Test plan
All scenarios use K=3, WORD_SIZE=8, IMG_WIDTH=8, IMG_HEIGHT=6, SHIFT=0 unless noted.
- Identity kernel (center=1), pixel = row*8+col, `in_sof` on the first pixel. Expect the first `out_valid` with `out_sof` 4 cycles after pixel (2,2), value 9; 24 outputs total, in order 9,10,…
- All-ones kernel: all pixels 100 → every output is 127. All pixels -100 → every output is -128. With `relu_en`=1, the -100 frame gives 0.
- SHIFT=3, all-ones kernel: pixels 10 → 11; pixels -10 → -12 (floor).
- `in_valid` toggling every cycle through the identity-kernel frame → same 24 values; output spacing equals input spacing.
- `reset_n` pulled low mid-frame → outputs and `overrun` read 0 immediately. After release, no `out_valid` until `in_sof`; a fresh frame then matches scenario 1.
- 49th pixel sent without `in_sof` → no output and `overrun`=1. The next `in_sof` pixel clears `overrun` and restarts at (0,0).
